// File: rtl/dcache_miss_ctrl_pkg.sv
// Shared types for the cache miss controller: memory request payload, cache IDs, FSM states.
package dcache_miss_ctrl_pkg;

  localparam int ADDR_WIDTH        = 32;
  localparam int DCACHE_LINE_WIDTH = 128;

  localparam logic ICACHE_ID = 1'b0;
  localparam logic DCACHE_ID = 1'b1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]        addr;
    logic                         is_store;
    logic [DCACHE_LINE_WIDTH-1:0] data;
  } memory_request_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WB_REQ    = 3'd1,
    WB_WAIT   = 3'd2,
    FILL_REQ  = 3'd3,
    FILL_WAIT = 3'd4
  } miss_ctrl_state_t;

endpackage

// File: rtl/dcache_miss_ctrl_if.sv
// Miss-side bundle: cache miss request, arbiter request, shared response bus and fill return.
interface dcache_miss_ctrl_if;
  import dcache_miss_ctrl_pkg::*;

  logic                         miss_valid;
  logic [ADDR_WIDTH-1:0]        miss_line_addr;
  logic                         victim_dirty;
  logic [ADDR_WIDTH-1:0]        victim_line_addr;
  logic [DCACHE_LINE_WIDTH-1:0] victim_data;
  logic                         miss_ready;
  logic                         req_valid_miss;
  memory_request_t              req_info_miss;
  logic                         rsp_valid_miss;
  logic                         rsp_cache_id;
  logic [DCACHE_LINE_WIDTH-1:0] rsp_data_miss;
  logic                         rsp_bus_error;
  logic                         fill_valid;
  logic [ADDR_WIDTH-1:0]        fill_line_addr;
  logic [DCACHE_LINE_WIDTH-1:0] fill_data;
  logic                         fill_error;

  // master: cache plus memory side; slave: the miss controller
  modport master (
    output miss_valid, miss_line_addr, victim_dirty, victim_line_addr, victim_data,
    output rsp_valid_miss, rsp_cache_id, rsp_data_miss, rsp_bus_error,
    input  miss_ready, req_valid_miss, req_info_miss,
    input  fill_valid, fill_line_addr, fill_data, fill_error
  );

  modport slave (
    input  miss_valid, miss_line_addr, victim_dirty, victim_line_addr, victim_data,
    input  rsp_valid_miss, rsp_cache_id, rsp_data_miss, rsp_bus_error,
    output miss_ready, req_valid_miss, req_info_miss,
    output fill_valid, fill_line_addr, fill_data, fill_error
  );

endinterface

// File: rtl/dcache_miss_ctrl_timeout.sv
// Wait-state counter; expired flags the last allowed wait cycle so the abort lands one cycle later.
module miss_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST    = CW'(TIMEOUT_CYCLES - 1);
  localparam bit            HAS_TMO = (TIMEOUT_CYCLES != 0);

  logic [CW-1:0] count_q;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (enable && !expired) begin
      count_q <= count_q + CW'(1);
    end
  end

  assign expired = HAS_TMO && enable && (count_q == LAST);

endmodule

// File: rtl/dcache_miss_ctrl.sv
// Miss handling unit: optional dirty writeback, then line refill, result returned to the cache.
//   state     | meaning
//   IDLE      | ready for a miss
//   WB_REQ    | writeback request pulse on the arbiter port
//   WB_WAIT   | waiting for the writeback response
//   FILL_REQ  | refill request pulse on the arbiter port
//   FILL_WAIT | waiting for the refill line
module dcache_miss_ctrl
  import dcache_miss_ctrl_pkg::*;
#(
  parameter logic CACHE_ID       = DCACHE_ID,
  parameter int   TIMEOUT_CYCLES = 256
) (
  input logic               clock,
  input logic               reset,
  dcache_miss_ctrl_if.slave bus
);

  miss_ctrl_state_t state_q, state_d;

  logic accept, rsp_match, in_wait, tmo_expired;

  logic                         req_valid_q, req_valid_d;
  memory_request_t              req_info_q, req_info_d;
  logic                         fill_valid_q, fill_valid_d;
  logic                         fill_error_q, fill_error_d;
  logic [DCACHE_LINE_WIDTH-1:0] fill_data_q, fill_data_d;
  logic [ADDR_WIDTH-1:0]        fill_addr_q, fill_addr_d;

  assign bus.miss_ready = (state_q == IDLE) && !reset;
  assign accept         = bus.miss_valid && bus.miss_ready;
  assign rsp_match      = bus.rsp_valid_miss && (bus.rsp_cache_id == CACHE_ID);
  assign in_wait        = (state_q == WB_WAIT) || (state_q == FILL_WAIT);

  miss_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (!in_wait),
    .enable (in_wait),
    .expired(tmo_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      req_valid_q  <= 1'b0;
      req_info_q   <= '0;
      fill_valid_q <= 1'b0;
      fill_error_q <= 1'b0;
      fill_data_q  <= '0;
      fill_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      req_valid_q  <= req_valid_d;
      req_info_q   <= req_info_d;
      fill_valid_q <= fill_valid_d;
      fill_error_q <= fill_error_d;
      fill_data_q  <= fill_data_d;
      fill_addr_q  <= fill_addr_d;
    end
  end

  // A response seen in the same cycle as the timeout takes priority.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (accept) state_d = bus.victim_dirty ? WB_REQ : FILL_REQ;
      WB_REQ:    state_d = WB_WAIT;
      WB_WAIT: begin
        if (rsp_match)        state_d = bus.rsp_bus_error ? IDLE : FILL_REQ;
        else if (tmo_expired) state_d = IDLE;
      end
      FILL_REQ:  state_d = FILL_WAIT;
      FILL_WAIT: if (rsp_match || tmo_expired) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // The request register doubles as the latch for victim address and data.
  always_comb begin
    req_valid_d  = 1'b0;
    req_info_d   = req_info_q;
    fill_valid_d = 1'b0;
    fill_error_d = fill_error_q;
    fill_data_d  = fill_data_q;
    fill_addr_d  = fill_addr_q;

    if (accept) fill_addr_d = bus.miss_line_addr;

    if (state_d == WB_REQ) begin
      req_valid_d         = 1'b1;
      req_info_d.addr     = bus.victim_line_addr;
      req_info_d.is_store = 1'b1;
      req_info_d.data     = bus.victim_data;
    end else if (state_d == FILL_REQ) begin
      req_valid_d         = 1'b1;
      req_info_d.addr     = fill_addr_d;
      req_info_d.is_store = 1'b0;
      req_info_d.data     = '0;
    end

    case (state_q)
      WB_WAIT: begin
        if ((rsp_match && bus.rsp_bus_error) || (!rsp_match && tmo_expired)) begin
          fill_valid_d = 1'b1;
          fill_error_d = 1'b1;
        end
      end
      FILL_WAIT: begin
        if (rsp_match) begin
          fill_valid_d = 1'b1;
          fill_error_d = bus.rsp_bus_error;
          fill_data_d  = bus.rsp_data_miss;
        end else if (tmo_expired) begin
          fill_valid_d = 1'b1;
          fill_error_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.req_valid_miss = req_valid_q;
  assign bus.req_info_miss  = req_info_q;
  assign bus.fill_valid     = fill_valid_q;
  assign bus.fill_error     = fill_error_q;
  assign bus.fill_data      = fill_data_q;
  assign bus.fill_line_addr = fill_addr_q;

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed bench for dcache_miss_ctrl: clean, dirty, foreign-ID, bus-error, timeout and reset cases.
module tb_dcache_miss_ctrl;
  import dcache_miss_ctrl_pkg::*;

  localparam logic [DCACHE_LINE_WIDTH-1:0] D_AA = {16{8'hAA}};
  localparam logic [DCACHE_LINE_WIDTH-1:0] D_55 = {16{8'h55}};
  localparam logic [DCACHE_LINE_WIDTH-1:0] D_CC = {16{8'hCC}};
  localparam logic [DCACHE_LINE_WIDTH-1:0] D_77 = {16{8'h77}};
  localparam logic [DCACHE_LINE_WIDTH-1:0] D_11 = {16{8'h11}};
  localparam logic [DCACHE_LINE_WIDTH-1:0] D_22 = {16{8'h22}};

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dcache_miss_ctrl_if bus ();
  dcache_miss_ctrl_if bus_to ();

  dcache_miss_ctrl #(.CACHE_ID(DCACHE_ID), .TIMEOUT_CYCLES(256)) u_dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  dcache_miss_ctrl #(.CACHE_ID(DCACHE_ID), .TIMEOUT_CYCLES(4)) u_dut_to (
    .clock(clock), .reset(reset), .bus(bus_to)
  );

  int checks = 0;
  int errors = 0;
  int req_count = 0;
  int base;
  logic found;
  memory_request_t exp_req;

  always @(negedge clock) if (bus.req_valid_miss) req_count++;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.miss_valid = 0; bus.miss_line_addr = '0; bus.victim_dirty = 0;
    bus.victim_line_addr = '0; bus.victim_data = '0;
    bus.rsp_valid_miss = 0; bus.rsp_cache_id = 0; bus.rsp_data_miss = '0; bus.rsp_bus_error = 0;
    bus_to.miss_valid = 0; bus_to.miss_line_addr = '0; bus_to.victim_dirty = 0;
    bus_to.victim_line_addr = '0; bus_to.victim_data = '0;
    bus_to.rsp_valid_miss = 0; bus_to.rsp_cache_id = 0; bus_to.rsp_data_miss = '0; bus_to.rsp_bus_error = 0;
  endtask

  task automatic miss(input logic [ADDR_WIDTH-1:0] a, input logic dirty,
                      input logic [ADDR_WIDTH-1:0] va, input logic [DCACHE_LINE_WIDTH-1:0] vd);
    bus.miss_valid = 1; bus.miss_line_addr = a; bus.victim_dirty = dirty;
    bus.victim_line_addr = va; bus.victim_data = vd;
    tick();
    bus.miss_valid = 0;
  endtask

  task automatic respond(input logic id, input logic err, input logic [DCACHE_LINE_WIDTH-1:0] d);
    bus.rsp_valid_miss = 1; bus.rsp_cache_id = id; bus.rsp_bus_error = err; bus.rsp_data_miss = d;
    tick();
    bus.rsp_valid_miss = 0; bus.rsp_bus_error = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    tick(); tick();
    chk("rst_miss_ready_in_reset", bus.miss_ready, 0);
    chk("rst_req_valid", bus.req_valid_miss, 0);
    chk("rst_req_info", bus.req_info_miss, 0);
    chk("rst_fill_valid", bus.fill_valid, 0);
    chk("rst_fill_error", bus.fill_error, 0);
    chk("rst_fill_data", bus.fill_data, 0);
    chk("rst_fill_addr", bus.fill_line_addr, 0);
    reset = 0;
    #1;
    chk("rst_miss_ready_after", bus.miss_ready, 1);

    // clean miss 0x40, response ten cycles later
    base = req_count;
    miss(32'h40, 0, 32'h999, D_55);
    exp_req = '{addr: 32'h40, is_store: 1'b0, data: '0};
    chk("clean_req_valid", bus.req_valid_miss, 1);
    chk("clean_req_info", bus.req_info_miss, exp_req);
    chk("clean_busy", bus.miss_ready, 0);
    for (int i = 0; i < 10; i++) tick();
    chk("clean_no_early_fill", bus.fill_valid, 0);
    respond(1, 0, D_AA);
    chk("clean_fill_valid", bus.fill_valid, 1);
    chk("clean_fill_data", bus.fill_data, D_AA);
    chk("clean_fill_error", bus.fill_error, 0);
    chk("clean_fill_addr", bus.fill_line_addr, 32'h40);
    chk("clean_ready_at_fill", bus.miss_ready, 1);
    chk("clean_req_count", req_count - base, 1);
    tick();
    chk("clean_fill_pulse", bus.fill_valid, 0);

    // dirty miss: store victim 0x10, then load 0x20
    base = req_count;
    miss(32'h20, 1, 32'h10, D_55);
    exp_req = '{addr: 32'h10, is_store: 1'b1, data: D_55};
    chk("dirty_wb_valid", bus.req_valid_miss, 1);
    chk("dirty_wb_info", bus.req_info_miss, exp_req);
    tick(); tick(); tick();
    chk("dirty_no_load_before_rsp", req_count - base, 1);
    respond(1, 0, 128'h1234);
    found = 0;
    for (int i = 0; i < 4 && !found; i++) begin
      if (bus.req_valid_miss) found = 1;
      else tick();
    end
    chk("dirty_load_seen", found, 1);
    exp_req = '{addr: 32'h20, is_store: 1'b0, data: '0};
    chk("dirty_load_info", bus.req_info_miss, exp_req);
    tick(); tick();
    respond(1, 0, D_CC);
    chk("dirty_fill_valid", bus.fill_valid, 1);
    chk("dirty_fill_data", bus.fill_data, D_CC);
    chk("dirty_fill_addr", bus.fill_line_addr, 32'h20);
    chk("dirty_req_count", req_count - base, 2);
    tick();

    // response for the other cache is ignored
    miss(32'h80, 0, 32'h0, '0);
    tick();
    respond(0, 0, 128'hDEAD);
    chk("foreign_no_fill", bus.fill_valid, 0);
    chk("foreign_still_busy", bus.miss_ready, 0);
    tick(); tick();
    chk("foreign_no_fill_later", bus.fill_valid, 0);
    respond(1, 0, D_77);
    chk("foreign_fill_valid", bus.fill_valid, 1);
    chk("foreign_fill_data", bus.fill_data, D_77);
    chk("foreign_fill_addr", bus.fill_line_addr, 32'h80);
    tick();

    // bus error on writeback aborts the refill
    miss(32'h50, 1, 32'h30, D_CC);
    tick();
    base = req_count;
    respond(1, 1, '0);
    chk("wberr_fill_valid", bus.fill_valid, 1);
    chk("wberr_fill_error", bus.fill_error, 1);
    chk("wberr_fill_addr", bus.fill_line_addr, 32'h50);
    chk("wberr_ready", bus.miss_ready, 1);
    tick(); tick(); tick();
    chk("wberr_no_load", req_count - base, 0);
    chk("wberr_fill_pulse", bus.fill_valid, 0);

    // timeout instance: no response, abort 4 cycles after FILL_WAIT entry
    bus_to.miss_valid = 1; bus_to.miss_line_addr = 32'hA0;
    tick();
    bus_to.miss_valid = 0;
    chk("tmo_req_valid", bus_to.req_valid_miss, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("tmo_not_yet", bus_to.fill_valid, 0);
      tick();
    end
    chk("tmo_fill_valid", bus_to.fill_valid, 1);
    chk("tmo_fill_error", bus_to.fill_error, 1);
    chk("tmo_fill_addr", bus_to.fill_line_addr, 32'hA0);
    tick();
    chk("tmo_fill_pulse", bus_to.fill_valid, 0);
    chk("tmo_ready", bus_to.miss_ready, 1);

    // response in the same cycle as the timeout wins
    bus_to.miss_valid = 1; bus_to.miss_line_addr = 32'hB0;
    tick();
    bus_to.miss_valid = 0;
    tick(); tick(); tick(); tick();
    bus_to.rsp_valid_miss = 1; bus_to.rsp_cache_id = 1; bus_to.rsp_data_miss = D_22;
    tick();
    bus_to.rsp_valid_miss = 0;
    chk("tmo_tie_fill_valid", bus_to.fill_valid, 1);
    chk("tmo_tie_fill_error", bus_to.fill_error, 0);
    chk("tmo_tie_fill_data", bus_to.fill_data, D_22);
    tick();

    // reset in WB_WAIT, stray response ignored, then a normal miss
    miss(32'h70, 1, 32'h60, D_AA);
    tick();
    reset = 1;
    tick();
    reset = 0;
    #1;
    chk("rstwait_ready", bus.miss_ready, 1);
    chk("rstwait_req_valid", bus.req_valid_miss, 0);
    chk("rstwait_req_info", bus.req_info_miss, 0);
    chk("rstwait_fill_addr", bus.fill_line_addr, 0);
    respond(1, 0, D_CC);
    chk("rstwait_stray_ignored", bus.fill_valid, 0);
    base = req_count;
    miss(32'h90, 0, 32'h0, '0);
    tick();
    respond(1, 0, D_11);
    chk("rstwait_fill_valid", bus.fill_valid, 1);
    chk("rstwait_fill_data", bus.fill_data, D_11);
    chk("rstwait_fill_addr2", bus.fill_line_addr, 32'h90);
    chk("rstwait_req_count", req_count - base, 1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
